// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: FSM state codes, input synchronizer depth and spi_mode decode helpers.
// SPI_SLAVE_INPUT_SYNC_EN selects two-flop input synchronizers; otherwise one register stage.
package spi_slave_pkg;

   localparam int unsigned STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ST_LOAD  = 2'd1;
   localparam logic [STATE_W-1:0] ST_SHIFT = 2'd2;

`ifdef SPI_SLAVE_INPUT_SYNC_EN
   localparam int unsigned SYNC_STAGES = 2;
`else
   localparam int unsigned SYNC_STAGES = 1;
`endif

   function automatic logic mode_cpol(input logic [1:0] mode);
      return mode[1];
   endfunction

   function automatic logic mode_cpha(input logic [1:0] mode);
      return mode[0];
   endfunction

   // Data is sampled on the rising sclk edge when cpol and cpha agree.
   function automatic logic sample_rising(input logic [1:0] mode);
      return mode_cpol(mode) == mode_cpha(mode);
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Single-bit input synchronizer; two flops with SPI_SLAVE_INPUT_SYNC_EN, else one register.
module spi_input_sync
   import spi_slave_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

`ifdef SPI_SLAVE_INPUT_SYNC_EN
   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end
`else
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= RESET_VAL;
      else     sync_q <= d_i;
   end
`endif

   assign q_o = sync_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave with AXI-Stream TX/RX word ports, runtime mode, bit order and word width.
// Define SPI_SLAVE_INPUT_SYNC_EN for two-flop input synchronizers (default: one stage).
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int unsigned AXIS_DATA_WIDTH = 8,
   localparam int unsigned WORD_COUNTER_WIDTH = $clog2(AXIS_DATA_WIDTH) + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   input  logic                          sclk,
   input  logic                          mosi,
   input  logic                          cs_n,
   output logic                          miso_o,
   output logic                          miso_t,
   input  logic                          enable,
   input  logic                          lsb_first,
   input  logic [1:0]                    spi_mode,
   input  logic [WORD_COUNTER_WIDTH-1:0] spi_word_width,
   output logic                          rx_overrun_error,
   output logic                          tx_underrun_error,
   output logic                          bus_active
);

   localparam int unsigned W  = AXIS_DATA_WIDTH;
   localparam int unsigned CW = WORD_COUNTER_WIDTH;
   localparam logic [CW-1:0] WIDTH_MAX = CW'(AXIS_DATA_WIDTH);

   logic sclk_s, mosi_s, cs_n_s;

   spi_input_sync #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s));
   spi_input_sync #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s));
   spi_input_sync #(.RESET_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst(rst), .d_i(cs_n), .q_o(cs_n_s));

   logic [STATE_W-1:0]     state_q, state_d;
   logic [1:0]             mode_q, mode_d;
   logic                   lsb_q, lsb_d;
   logic [CW-1:0]          width_q, width_d, bit_cnt_q, bit_cnt_d;
   logic [W-1:0]           tx_hold_q, tx_hold_d, tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
   logic [W-1:0]           m_tdata_q, m_tdata_d;
   logic                   tx_hold_valid_q, tx_hold_valid_d, miso_q, miso_d;
   logic                   m_tvalid_q, m_tvalid_d, overrun_q, overrun_d, underrun_q, underrun_d;
   logic                   armed_q, armed_d, sclk_prev_q;
   logic [SYNC_STAGES-1:0] prime_q;

   logic [CW-1:0] cnt_inc, align_sh;
   logic [W-1:0]  tx_load, rx_next, rx_word;
   logic          sclk_rise, sclk_fall, sample_edge, drive_edge;

   function automatic logic first_bit(input logic [W-1:0] sr, input logic lsb);
      return lsb ? sr[0] : sr[W-1];
   endfunction

   function automatic logic [W-1:0] shift_out(input logic [W-1:0] sr, input logic lsb);
      return lsb ? (sr >> 1) : (sr << 1);
   endfunction

   assign sclk_rise   = sclk_s & ~sclk_prev_q;
   assign sclk_fall   = ~sclk_s & sclk_prev_q;
   assign sample_edge = sample_rising(mode_q) ? sclk_rise : sclk_fall;
   assign drive_edge  = sample_rising(mode_q) ? sclk_fall : sclk_rise;
   assign cnt_inc     = bit_cnt_q + CW'(1);
   assign align_sh    = WIDTH_MAX - width_q;

   // MSB-first words are pre-aligned so the first bit always leaves from bit W-1.
   always_comb begin
      tx_load = tx_hold_valid_q ? tx_hold_q : '0;
      if (!lsb_q) tx_load = tx_load << align_sh;
      rx_next = lsb_q ? {mosi_s, rx_sr_q[W-1:1]} : {rx_sr_q[W-2:0], mosi_s};
      rx_word = lsb_q ? (rx_next >> align_sh) : rx_next;
   end

   always_comb begin
      state_d         = state_q;
      mode_d          = mode_q;
      lsb_d           = lsb_q;
      width_d         = width_q;
      bit_cnt_d       = bit_cnt_q;
      tx_hold_d       = tx_hold_q;
      tx_hold_valid_d = tx_hold_valid_q;
      tx_sr_d         = tx_sr_q;
      rx_sr_d         = rx_sr_q;
      miso_d          = miso_q;
      m_tdata_d       = m_tdata_q;
      m_tvalid_d      = m_tvalid_q;
      overrun_d       = overrun_q;
      underrun_d      = 1'b0;
      armed_d         = armed_q | (cs_n_s & prime_q[SYNC_STAGES-1]);

      if (s_axis_tvalid && s_axis_tready) begin
         tx_hold_d       = s_axis_tdata;
         tx_hold_valid_d = 1'b1;
      end
      if (m_tvalid_q && m_axis_tready) begin
         m_tvalid_d = 1'b0;
         overrun_d  = 1'b0;
      end

      if (cs_n_s) begin
         state_d = ST_IDLE;
         miso_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               miso_d = 1'b0;
               if (enable && armed_q) begin
                  state_d = ST_LOAD;
                  mode_d  = spi_mode;
                  lsb_d   = lsb_first;
                  width_d = (spi_word_width == '0 || spi_word_width > WIDTH_MAX) ?
                            WIDTH_MAX : spi_word_width;
               end
            end
            ST_LOAD: begin
               state_d    = ST_SHIFT;
               bit_cnt_d  = '0;
               rx_sr_d    = '0;
               underrun_d = !tx_hold_valid_q;
               if (tx_hold_valid_q) tx_hold_valid_d = 1'b0;
               if (!mode_cpha(mode_q)) begin
                  miso_d  = first_bit(tx_load, lsb_q);
                  tx_sr_d = shift_out(tx_load, lsb_q);
               end else begin
                  tx_sr_d = tx_load;
               end
            end
            ST_SHIFT: begin
               // With cpha=0 the drive edge trailing the previous word must not advance the new one.
               if (drive_edge && (mode_cpha(mode_q) || bit_cnt_q != '0)) begin
                  miso_d  = first_bit(tx_sr_q, lsb_q);
                  tx_sr_d = shift_out(tx_sr_q, lsb_q);
               end
               if (sample_edge) begin
                  rx_sr_d   = rx_next;
                  bit_cnt_d = cnt_inc;
                  if (cnt_inc == width_q) begin
                     state_d    = ST_LOAD;
                     m_tdata_d  = rx_word;
                     m_tvalid_d = 1'b1;
                     if (m_tvalid_q && !m_axis_tready) overrun_d = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         mode_q          <= '0;
         lsb_q           <= 1'b0;
         width_q         <= '0;
         bit_cnt_q       <= '0;
         tx_hold_q       <= '0;
         tx_hold_valid_q <= 1'b0;
         tx_sr_q         <= '0;
         rx_sr_q         <= '0;
         miso_q          <= 1'b0;
         m_tdata_q       <= '0;
         m_tvalid_q      <= 1'b0;
         overrun_q       <= 1'b0;
         underrun_q      <= 1'b0;
         armed_q         <= 1'b0;
         sclk_prev_q     <= 1'b0;
         prime_q         <= '0;
      end else begin
         state_q         <= state_d;
         mode_q          <= mode_d;
         lsb_q           <= lsb_d;
         width_q         <= width_d;
         bit_cnt_q       <= bit_cnt_d;
         tx_hold_q       <= tx_hold_d;
         tx_hold_valid_q <= tx_hold_valid_d;
         tx_sr_q         <= tx_sr_d;
         rx_sr_q         <= rx_sr_d;
         miso_q          <= miso_d;
         m_tdata_q       <= m_tdata_d;
         m_tvalid_q      <= m_tvalid_d;
         overrun_q       <= overrun_d;
         underrun_q      <= underrun_d;
         armed_q         <= armed_d;
         sclk_prev_q     <= sclk_s;
         prime_q         <= SYNC_STAGES'({prime_q, 1'b1});
      end
   end

   assign s_axis_tready     = enable && !tx_hold_valid_q;
   assign m_axis_tdata      = m_tdata_q;
   assign m_axis_tvalid     = m_tvalid_q;
   assign miso_o            = miso_q;
   assign miso_t            = (state_q == ST_IDLE);
   assign bus_active        = (state_q != ST_IDLE);
   assign rx_overrun_error  = overrun_q;
   assign tx_underrun_error = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bit-banged SPI master drives frames, a monitor checks m_axis words.
module tb_spi_slave;

   localparam int unsigned W    = 8;
   localparam int unsigned CW   = $clog2(W) + 1;
   localparam int unsigned HALF = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [W-1:0]  m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          sclk, mosi, cs_n;
   logic          miso_o, miso_t;
   logic          enable, lsb_first;
   logic [1:0]    spi_mode;
   logic [CW-1:0] spi_word_width;
   logic          rx_overrun_error, tx_underrun_error, bus_active;

   int n_tests = 0;
   int n_fail  = 0;
   int ucnt    = 0;
   int ucnt_start = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] miso_word;
   int u0;

   spi_slave #(.AXIS_DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso_o(miso_o), .miso_t(miso_t),
      .enable(enable), .lsb_first(lsb_first), .spi_mode(spi_mode), .spi_word_width(spi_word_width),
      .rx_overrun_error(rx_overrun_error), .tx_underrun_error(tx_underrun_error),
      .bus_active(bus_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted m_axis word must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL m_axis_unexpected: got 0x%0h expected no word", m_axis_tdata);
         end else begin
            chk("m_axis_tdata", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
         end
      end
      if (tx_underrun_error) ucnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic s_push(input logic [W-1:0] d);
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      for (int t = 0; t < 50 && !s_axis_tready; t++) wait_clk(1);
      chk("s_axis_tready", 32'(s_axis_tready), 32'd1);
      wait_clk(1);
      s_axis_tvalid = 1'b0;
   endtask

   // SPI master: nbits=0 sends all words; keep_cs leaves cs_n low after the last bit.
   task automatic spi_frame(input logic [1:0] mode, input logic lsb, input int width,
                            input logic [W-1:0] w0, input logic [W-1:0] w1, input int nwords,
                            input int nbits, input logic exp_active, input logic keep_cs,
                            output logic [W-1:0] miso0);
      logic bits[$];
      logic got[$];
      logic [W-1:0] w;
      logic cpha;
      int total;
      cpha           = mode[0];
      spi_mode       = mode;
      lsb_first      = lsb;
      spi_word_width = CW'(width);
      sclk           = mode[1];
      for (int k = 0; k < nwords; k++) begin
         w = (k == 0) ? w0 : w1;
         for (int i = 0; i < width; i++) bits.push_back(w[lsb ? i : width - 1 - i]);
      end
      total = (nbits == 0) ? bits.size() : nbits;
      wait_clk(4);
      cs_n = 1'b0;
      if (!cpha) mosi = bits[0];
      wait_clk(HALF);
      ucnt_start = ucnt;
      chk("bus_active_in_frame", 32'(bus_active), 32'(exp_active));
      chk("miso_t_in_frame", 32'(miso_t), 32'(!exp_active));
      for (int i = 0; i < total; i++) begin
         if (cpha) begin
            sclk = ~sclk;
            mosi = bits[i];
            wait_clk(HALF);
         end
         sclk = ~sclk;
         got.push_back(miso_o);
         wait_clk(HALF);
         if (!cpha) begin
            sclk = ~sclk;
            if (i + 1 < total) mosi = bits[i + 1];
            wait_clk(HALF);
         end
      end
      miso0 = '0;
      for (int i = 0; i < width && i < got.size(); i++) miso0[lsb ? i : width - 1 - i] = got[i];
      if (!keep_cs) begin
         cs_n = 1'b1;
         wait_clk(4);
         chk("bus_active_after_cs", 32'(bus_active), 32'd0);
         chk("miso_t_after_cs", 32'(miso_t), 32'd1);
         chk("miso_o_after_cs", 32'(miso_o), 32'd0);
         wait_clk(4);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
      sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
      enable = 1'b1; lsb_first = 1'b0; spi_mode = 2'd0; spi_word_width = CW'(8);
      wait_clk(3);
      chk("rst_miso_o", 32'(miso_o), 32'd0);
      chk("rst_miso_t", 32'(miso_t), 32'd1);
      chk("rst_bus_active", 32'(bus_active), 32'd0);
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
      chk("rst_overrun", 32'(rx_overrun_error), 32'd0);
      chk("rst_underrun", 32'(tx_underrun_error), 32'd0);
      chk("rst_s_tready", 32'(s_axis_tready), 32'd1);
      rst = 1'b0;
      wait_clk(6);

      // Mode 0, MSB first, 8 bits
      s_push(8'hA5);
      exp_q.push_back(8'h3C);
      u0 = ucnt;
      spi_frame(2'd0, 1'b0, 8, 8'h3C, 8'h00, 1, 0, 1'b1, 1'b0, miso_word);
      chk("m0_miso", 32'(miso_word), 32'hA5);
      chk("m0_no_underrun_at_start", 32'(ucnt_start - u0), 32'd0);

      // Mode 3, LSB first, 5 bits
      s_push(8'h13);
      exp_q.push_back(8'h0B);
      spi_frame(2'd3, 1'b1, 5, 8'h0B, 8'h00, 1, 0, 1'b1, 1'b0, miso_word);
      chk("m3_lsb5_miso", 32'(miso_word), 32'h13);

      // Mode 1, MSB first; mode 2, LSB first
      s_push(8'h3A);
      exp_q.push_back(8'hE7);
      spi_frame(2'd1, 1'b0, 8, 8'hE7, 8'h00, 1, 0, 1'b1, 1'b0, miso_word);
      chk("m1_miso", 32'(miso_word), 32'h3A);
      s_push(8'hC6);
      exp_q.push_back(8'h1D);
      spi_frame(2'd2, 1'b1, 8, 8'h1D, 8'h00, 1, 0, 1'b1, 1'b0, miso_word);
      chk("m2_lsb_miso", 32'(miso_word), 32'hC6);

      // Two words with m_axis stalled: second overwrites first and flags overrun
      m_axis_tready = 1'b0;
      s_push(8'hF0);
      exp_q.push_back(8'h55);
      spi_frame(2'd0, 1'b0, 8, 8'hC3, 8'h55, 2, 0, 1'b1, 1'b0, miso_word);
      chk("ovr_miso_first", 32'(miso_word), 32'hF0);
      chk("ovr_m_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("ovr_m_tdata", 32'(m_axis_tdata), 32'h55);
      chk("ovr_flag_set", 32'(rx_overrun_error), 32'd1);
      m_axis_tready = 1'b1;
      wait_clk(2);
      chk("ovr_flag_clear", 32'(rx_overrun_error), 32'd0);
      chk("ovr_m_tvalid_clear", 32'(m_axis_tvalid), 32'd0);

      // No TX word: underrun pulse at frame start, zeros shifted out
      exp_q.push_back(8'h81);
      u0 = ucnt;
      spi_frame(2'd0, 1'b0, 8, 8'h81, 8'h00, 1, 0, 1'b1, 1'b0, miso_word);
      chk("udr_pulse_cycles", 32'(ucnt_start - u0), 32'd1);
      chk("udr_miso", 32'(miso_word), 32'h00);

      // cs_n released after 3 bits: no word out, TX word dropped
      s_push(8'h5A);
      spi_frame(2'd0, 1'b0, 8, 8'hFF, 8'h00, 1, 3, 1'b1, 1'b0, miso_word);
      chk("abort_miso_partial", 32'(miso_word), 32'h40);
      chk("abort_s_tready", 32'(s_axis_tready), 32'd1);
      chk("abort_m_tvalid", 32'(m_axis_tvalid), 32'd0);

      // Reset mid-word, then further edges with cs_n still low are ignored
      s_push(8'h99);
      spi_frame(2'd0, 1'b0, 8, 8'hAA, 8'h00, 1, 4, 1'b1, 1'b1, miso_word);
      rst = 1'b1;
      wait_clk(1);
      chk("midrst_bus_active", 32'(bus_active), 32'd0);
      chk("midrst_miso_t", 32'(miso_t), 32'd1);
      chk("midrst_miso_o", 32'(miso_o), 32'd0);
      chk("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("midrst_s_tready", 32'(s_axis_tready), 32'd1);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sclk = ~sclk;
         mosi = ~mosi;
         wait_clk(HALF);
      end
      chk("midrst_still_idle", 32'(bus_active), 32'd0);
      cs_n = 1'b1;
      wait_clk(6);
      s_push(8'h6E);
      exp_q.push_back(8'h92);
      spi_frame(2'd0, 1'b0, 8, 8'h92, 8'h00, 1, 0, 1'b1, 1'b0, miso_word);
      chk("postrst_miso", 32'(miso_word), 32'h6E);

      // enable low in IDLE blocks the frame
      enable = 1'b0;
      wait_clk(1);
      chk("dis_s_tready", 32'(s_axis_tready), 32'd0);
      spi_frame(2'd0, 1'b0, 8, 8'hFF, 8'h00, 1, 0, 1'b0, 1'b0, miso_word);
      chk("dis_miso", 32'(miso_word), 32'h00);
      enable = 1'b1;
      wait_clk(4);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter AXIS_DATA_WIDTH, default 8, maximum SPI word width and AXIS data width.
REQ-002 Localparam WORD_COUNTER_WIDTH = $clog2(AXIS_DATA_WIDTH)+1, bit counter width.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 s_axis_tdata/tvalid/tready  in/in/out  W/1/1  word to transmit on MISO.
REQ-006 m_axis_tdata/tvalid/tready  out/out/in  W/1/1  word received from MOSI.
REQ-007 sclk, mosi, cs_n  in  1 each  asynchronous SPI inputs from master; cs_n active-low.
REQ-008 miso_o, miso_t  out  1 each  MISO data and tristate enable (1 = high-Z).
REQ-009 enable, lsb_first, spi_mode[1:0], spi_word_width[WORD_COUNTER_WIDTH-1:0]  in  configuration.
REQ-010 rx_overrun_error, tx_underrun_error, bus_active  out  1 each  status.

Function
REQ-011 cpol = spi_mode[1], cpha = spi_mode[0]; sample edge = rising if cpol==cpha else falling; drive edge = opposite edge.
REQ-012 Edges detected on synchronized sclk (previous vs current sample); sclk must not exceed clk/8.
REQ-013 Configuration inputs latched at the cs_n assertion that starts a frame; stable thereafter until cs_n deasserts.
REQ-014 TX holding register: s_axis_tready = enable && !tx_hold_valid; one word buffered.
REQ-015 States IDLE, LOAD, SHIFT. IDLE->LOAD on synchronized cs_n low with enable; LOAD->SHIFT after one cycle; SHIFT->LOAD when bit counter reaches spi_word_width with cs_n still low; any state->IDLE on cs_n high.
REQ-016 LOAD: shift register loads tx_hold (clears tx_hold_valid); if tx_hold_valid=0, loads zero and pulses tx_underrun_error one cycle.
REQ-017 LOAD with cpha=0: first bit placed on miso_o in the same cycle; cpha=1: first bit placed on first drive edge.
REQ-018 Bit order: lsb_first=1 shifts bit 0 first; else bit spi_word_width-1 first; receive data right-aligned in both orders.
REQ-019 Each sample edge in SHIFT captures synchronized mosi and increments bit counter.
REQ-020 On last sample: m_axis_tdata <= received word, m_axis_tvalid <= 1 one cycle later; if m_axis_tvalid already 1 and not accepted that cycle, word overwritten and rx_overrun_error set.
REQ-021 rx_overrun_error clears on next accepted m_axis transfer.
REQ-022 cs_n deassert mid-word: partial receive discarded, no m_axis output, unsent TX word lost, miso_t <= 1 next cycle.
REQ-023 miso_t = 0 only while not IDLE; miso_o = 0 while IDLE.
REQ-024 bus_active = (state != IDLE).
REQ-025 enable deasserted in IDLE blocks frame start; deasserted mid-frame has no effect until IDLE.

Reset
REQ-026 rst: state IDLE, miso_o 0, miso_t 1, m_axis_tvalid 0, m_axis_tdata 0, tx_hold_valid 0, both errors 0, counters 0; synchronizers loaded with sclk=cpol-agnostic 0, cs_n=1.
REQ-027 rst mid-frame aborts the frame; remaining edges ignored until cs_n seen high then low.

Configuration
REQ-028 Macro SPI_SLAVE_INPUT_SYNC_EN defined: sclk, mosi, cs_n pass through two-flop synchronizers (input-to-edge latency 3 clk).
REQ-029 Macro undefined: single register stage (latency 2 clk); sclk limit relaxed to clk/6; function otherwise identical.

Structure
REQ-030 Shared package holds spi_mode decode (cpol/cpha helpers) and state enum, common with spi_master.
REQ-031 One sub-module spi_input_sync (per-bit synchronizer, depth by macro); instantiated three times.

Verification
REQ-032 Mode 0, MSB first, width 8: s_axis 0xA5, master sends 0x3C -> MISO bits 10100101, m_axis 0x3C.
REQ-033 Mode 3, LSB first, width 5: s_axis 0x13, master sends 0x0B -> MISO bits 1,1,0,0,1; m_axis 0x0B.
REQ-034 Two 8-bit words in one cs_n frame, m_axis_tready=0 -> second word 0x55 on m_axis, rx_overrun_error=1; clears after tready accept.
REQ-035 No s_axis word at cs_n assertion -> tx_underrun_error 1-cycle pulse, MISO shifts 0x00.
REQ-036 cs_n high after 3 bits -> no m_axis_tvalid, miso_t=1, bus_active=0 within sync latency +1.
REQ-037 rst asserted mid-word -> all outputs at reset values next cycle; next full frame received correctly.
